mcoi_step_scheduler: RTL and testbench

//  Time-multiplexed step/direction sequencer for the 16 stepper drivers on the motors bundle (pl_clk/dir/en/boost).

---
 rtl/mcoi_step_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_mcoi_step_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcoi_step_scheduler.sv
// Round-robin step/direction sequencer: one motor slot is serviced per clock, one job per motor.
// Optional define MCOI_STEP_BOOST_EN drives pl_boost_ob from the command while the job is running.
module mcoi_step_scheduler #(
  parameter int NMOTORS = 16,
  parameter int STEP_W  = 24,
  parameter int DIV_W   = 16
) (
  input  logic                       Clk_ik,
  input  logic                       Reset_ir,
  input  logic                       CmdValid_i,
  output logic                       CmdReady_o,
  input  logic [$clog2(NMOTORS)-1:0] CmdMotor_ib,
  input  logic [STEP_W-1:0]          CmdSteps_ib,
  input  logic                       CmdDir_i,
  input  logic                       CmdBoost_i,
  input  logic [DIV_W-1:0]           CmdHalfPer_ib,
  input  logic [NMOTORS-1:0]         Abort_ib,
  input  logic [NMOTORS-1:0]         Release_ib,
  output logic [NMOTORS-1:0]         pl_clk_ob,
  output logic [NMOTORS-1:0]         pl_dir_ob,
  output logic [NMOTORS-1:0]         pl_en_ob,
  output logic [NMOTORS-1:0]         pl_boost_ob,
  input  logic [NMOTORS-1:0]         pl_pfail_ib,
  input  logic [NMOTORS-1:0]         pl_sw_outa_ib,
  input  logic [NMOTORS-1:0]         pl_sw_outb_ib,
  output logic [NMOTORS-1:0]         Busy_ob,
  output logic [NMOTORS-1:0]         Fault_ob,
  output logic                       Done_o,
  output logic [$clog2(NMOTORS)-1:0] DoneMotor_ob,
  output logic [1:0]                 DoneStat_ob
);
  localparam int MW = $clog2(NMOTORS);
  typedef logic [MW-1:0] motor_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_LIMIT = 2'b01;
  localparam logic [1:0] ST_PFAIL = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  motor_t              slot_q, slot_d;
  logic [NMOTORS-1:0]  busy_q, busy_d, en_q, en_d, dir_q, dir_d;
  logic [NMOTORS-1:0]  clk_q, clk_d, boost_q, boost_d, fault_q, fault_d;
  logic [DIV_W-1:0]    div_q [NMOTORS];
  logic [DIV_W-1:0]    div_d [NMOTORS];
  logic [DIV_W-1:0]    cnt_q [NMOTORS];
  logic [DIV_W-1:0]    cnt_d [NMOTORS];
  logic [STEP_W-1:0]   rem_q [NMOTORS];
  logic [STEP_W-1:0]   rem_d [NMOTORS];
  logic                done_q, done_d;
  motor_t              done_motor_q, done_motor_d;
  logic [1:0]          done_stat_q, done_stat_d;
  logic                end_job;
  logic [1:0]          end_stat;
  logic [DIV_W-1:0]    half_per;

`ifndef MCOI_STEP_BOOST_EN
  logic unused_boost;
  assign unused_boost = CmdBoost_i;
`endif

  // State register: per-motor IDLE/RUN is busy_q, exported on Busy_ob.
  always_ff @(posedge Clk_ik) begin
    if (Reset_ir) begin
      slot_q       <= '0;
      busy_q       <= '0;
      en_q         <= '0;
      dir_q        <= '0;
      clk_q        <= '0;
      boost_q      <= '0;
      fault_q      <= '0;
      done_q       <= 1'b0;
      done_motor_q <= '0;
      done_stat_q  <= ST_OK;
      for (int m = 0; m < NMOTORS; m++) begin
        div_q[m] <= '0;
        cnt_q[m] <= '0;
        rem_q[m] <= '0;
      end
    end else begin
      slot_q       <= slot_d;
      busy_q       <= busy_d;
      en_q         <= en_d;
      dir_q        <= dir_d;
      clk_q        <= clk_d;
      boost_q      <= boost_d;
      fault_q      <= fault_d;
      done_q       <= done_d;
      done_motor_q <= done_motor_d;
      done_stat_q  <= done_stat_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
    end
  end

  // Next state: service the slot motor, then idle releases, then an accepted command (wins last).
  always_comb begin
    slot_d       = slot_q + motor_t'(1);
    busy_d       = busy_q;
    en_d         = en_q;
    dir_d        = dir_q;
    clk_d        = clk_q;
    boost_d      = boost_q;
    fault_d      = fault_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    done_d       = 1'b0;
    done_motor_d = slot_q;
    done_stat_d  = ST_OK;
    end_job      = 1'b0;
    end_stat     = ST_OK;
    half_per     = (CmdHalfPer_ib == '0) ? DIV_W'(1) : CmdHalfPer_ib;

    if (busy_q[slot_q]) begin
      if (pl_pfail_ib[slot_q]) begin
        clk_d[slot_q]   = 1'b0;
        en_d[slot_q]    = 1'b0;
        fault_d[slot_q] = 1'b1;
        end_job         = 1'b1;
        end_stat        = ST_PFAIL;
      end else if (Abort_ib[slot_q]) begin
        clk_d[slot_q] = 1'b0;
        end_job       = 1'b1;
        end_stat      = ST_ABORT;
      end else if ((dir_q[slot_q] & pl_sw_outa_ib[slot_q]) |
                   (~dir_q[slot_q] & pl_sw_outb_ib[slot_q])) begin
        clk_d[slot_q] = 1'b0;
        end_job       = 1'b1;
        end_stat      = ST_LIMIT;
      end else if (rem_q[slot_q] == '0) begin
        end_job  = 1'b1;
        end_stat = ST_OK;
      end else if (cnt_q[slot_q] <= DIV_W'(1)) begin
        cnt_d[slot_q] = div_q[slot_q];
        clk_d[slot_q] = ~clk_q[slot_q];
        if (clk_q[slot_q]) begin
          rem_d[slot_q] = rem_q[slot_q] - STEP_W'(1);
          if (rem_q[slot_q] == STEP_W'(1)) begin
            end_job  = 1'b1;
            end_stat = ST_OK;
          end
        end
      end else begin
        cnt_d[slot_q] = cnt_q[slot_q] - DIV_W'(1);
      end
      if (end_job) begin
        busy_d[slot_q]  = 1'b0;
        boost_d[slot_q] = 1'b0;
        done_d          = 1'b1;
        done_stat_d     = end_stat;
      end
    end else if (pl_pfail_ib[slot_q] && en_q[slot_q]) begin
      en_d[slot_q]    = 1'b0;
      fault_d[slot_q] = 1'b1;
    end

    for (int m = 0; m < NMOTORS; m++) begin
      if (Release_ib[m] && !busy_q[m]) en_d[m] = 1'b0;
    end

    // Handshake: a command transfers on a cycle where CmdValid_i and CmdReady_o are both high;
    // ready is low while the addressed motor is busy, so the command is simply held off.
    if (CmdValid_i && !busy_q[CmdMotor_ib]) begin
      busy_d[CmdMotor_ib]  = 1'b1;
      en_d[CmdMotor_ib]    = 1'b1;
      dir_d[CmdMotor_ib]   = CmdDir_i;
      clk_d[CmdMotor_ib]   = 1'b0;
      fault_d[CmdMotor_ib] = 1'b0;
      div_d[CmdMotor_ib]   = half_per;
      cnt_d[CmdMotor_ib]   = half_per;
      rem_d[CmdMotor_ib]   = CmdSteps_ib;
`ifdef MCOI_STEP_BOOST_EN
      boost_d[CmdMotor_ib] = CmdBoost_i;
`else
      boost_d[CmdMotor_ib] = 1'b0;
`endif
    end
  end

  // Outputs come straight from registers, except the combinational ready.
  always_comb begin
    CmdReady_o   = ~busy_q[CmdMotor_ib];
    pl_clk_ob    = clk_q;
    pl_dir_ob    = dir_q;
    pl_en_ob     = en_q;
    pl_boost_ob  = boost_q;
    Busy_ob      = busy_q;
    Fault_ob     = fault_q;
    Done_o       = done_q;
    DoneMotor_ob = done_motor_q;
    DoneStat_ob  = done_stat_q;
  end
endmodule

// File: tb/tb_mcoi_step_scheduler.sv
// Testbench for mcoi_step_scheduler: scenario tasks plus randomized rounds checked against
// job-level expectations (pulse counts, pulse widths, end status, final enable/fault state).
`timescale 1ns/1ps
module tb_mcoi_step_scheduler;
  localparam int NM = 16;
  localparam int SW = 24;
  localparam int DW = 16;
`ifdef MCOI_STEP_BOOST_EN
  localparam bit BOOST_EN = 1'b1;
`else
  localparam bit BOOST_EN = 1'b0;
`endif

  logic          Clk_ik = 1'b0;
  logic          Reset_ir = 1'b1;
  logic          CmdValid_i = 1'b0;
  logic          CmdReady_o;
  logic [3:0]    CmdMotor_ib = '0;
  logic [SW-1:0] CmdSteps_ib = '0;
  logic          CmdDir_i = 1'b0;
  logic          CmdBoost_i = 1'b0;
  logic [DW-1:0] CmdHalfPer_ib = '0;
  logic [NM-1:0] Abort_ib = '0;
  logic [NM-1:0] Release_ib = '0;
  logic [NM-1:0] pl_clk_ob, pl_dir_ob, pl_en_ob, pl_boost_ob;
  logic [NM-1:0] pl_pfail_ib = '0;
  logic [NM-1:0] pl_sw_outa_ib = '0;
  logic [NM-1:0] pl_sw_outb_ib = '0;
  logic [NM-1:0] Busy_ob, Fault_ob;
  logic          Done_o;
  logic [3:0]    DoneMotor_ob;
  logic [1:0]    DoneStat_ob;

  mcoi_step_scheduler #(.NMOTORS(NM), .STEP_W(SW), .DIV_W(DW)) dut (
    .Clk_ik(Clk_ik), .Reset_ir(Reset_ir),
    .CmdValid_i(CmdValid_i), .CmdReady_o(CmdReady_o), .CmdMotor_ib(CmdMotor_ib),
    .CmdSteps_ib(CmdSteps_ib), .CmdDir_i(CmdDir_i), .CmdBoost_i(CmdBoost_i),
    .CmdHalfPer_ib(CmdHalfPer_ib), .Abort_ib(Abort_ib), .Release_ib(Release_ib),
    .pl_clk_ob(pl_clk_ob), .pl_dir_ob(pl_dir_ob), .pl_en_ob(pl_en_ob), .pl_boost_ob(pl_boost_ob),
    .pl_pfail_ib(pl_pfail_ib), .pl_sw_outa_ib(pl_sw_outa_ib), .pl_sw_outb_ib(pl_sw_outb_ib),
    .Busy_ob(Busy_ob), .Fault_ob(Fault_ob), .Done_o(Done_o),
    .DoneMotor_ob(DoneMotor_ob), .DoneStat_ob(DoneStat_ob)
  );

  // Clock and cycle counter
  always #5 Clk_ik = ~Clk_ik;
  int cyc = 0;
  always @(posedge Clk_ik) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  // Observation: pulse counts, pulse widths against exp_half, and a queue of job-end events
  int rise_cnt[NM], bad_w[NM], exp_half[NM], rise_cyc[NM], fall_cyc[NM];
  bit have_fall[NM], prev_clk[NM];
  int base_rise[NM], base_bad[NM];
  int dq_m[$], dq_s[$], dq_c[$], dq_b[$];

  always @(negedge Clk_ik) begin
    for (int m = 0; m < NM; m++) begin
      if (pl_clk_ob[m] && !prev_clk[m]) begin
        rise_cnt[m]++;
        if (have_fall[m] && (cyc - fall_cyc[m]) != exp_half[m]) bad_w[m]++;
        rise_cyc[m] = cyc;
      end else if (!pl_clk_ob[m] && prev_clk[m]) begin
        if (!Reset_ir && !(Done_o && int'(DoneMotor_ob) == m && DoneStat_ob != 2'b00) &&
            (cyc - rise_cyc[m]) != exp_half[m]) bad_w[m]++;
        have_fall[m] = 1'b1;
        fall_cyc[m] = cyc;
      end
      prev_clk[m] = pl_clk_ob[m];
      if (!Busy_ob[m]) have_fall[m] = 1'b0;
    end
    if (Done_o) begin
      dq_m.push_back(int'(DoneMotor_ob));
      dq_s.push_back(int'(DoneStat_ob));
      dq_c.push_back(cyc);
      dq_b.push_back(int'(Busy_ob[DoneMotor_ob]));
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge Clk_ik);
    #1;
  endtask

  task automatic clear_dq();
    dq_m.delete(); dq_s.delete(); dq_c.delete(); dq_b.delete();
  endtask

  task automatic send_cmd(input int m, input int steps, input bit dir, input bit boost, input int hp);
    tick();
    exp_half[m]  = NM * ((hp == 0) ? 1 : hp);
    base_rise[m] = rise_cnt[m];
    base_bad[m]  = bad_w[m];
    CmdValid_i = 1'b1; CmdMotor_ib = 4'(m); CmdSteps_ib = SW'(steps);
    CmdDir_i = dir; CmdBoost_i = boost; CmdHalfPer_ib = DW'(hp);
    @(posedge Clk_ik);
    #1;
    CmdValid_i = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int k = 0;
    while (dq_m.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (dq_m.size() >= n);
  endtask

  task automatic wait_pulses(input int m, input int n);
    int k = 0;
    while ((rise_cnt[m] - base_rise[m]) < n && k < 4000) begin
      tick();
      k++;
    end
  endtask

  // Scenarios
  task automatic test_reset();
    logic [NM*6+7:0] outs;
    Reset_ir = 1'b1;
    repeat (3) @(posedge Clk_ik);
    tick();
    outs = {pl_clk_ob, pl_dir_ob, pl_en_ob, pl_boost_ob, Busy_ob, Fault_ob, Done_o, DoneMotor_ob, DoneStat_ob};
    n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL reset_outputs: got %0h expected 0", outs); end
    n_cmp++; if (CmdReady_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b expected 1", CmdReady_o); end
    Reset_ir = 1'b0;
    // Reset in the middle of a move on motor 5
    send_cmd(5, 100, 1'b1, 1'b1, 1);
    repeat (40) tick();
    n_cmp++; if (Busy_ob[5] !== 1'b1) begin n_err++; $display("FAIL reset_pre_busy: got %0b expected 1", Busy_ob[5]); end
    clear_dq();
    Reset_ir = 1'b1;
    tick();
    outs = {pl_clk_ob, pl_dir_ob, pl_en_ob, pl_boost_ob, Busy_ob, Fault_ob, Done_o, DoneMotor_ob, DoneStat_ob};
    n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL reset_mid_move: got %0h expected 0", outs); end
    Reset_ir = 1'b0;
    repeat (40) tick();
    n_cmp++; if (dq_m.size() != 0) begin n_err++; $display("FAIL reset_no_done: got %0d done expected 0", dq_m.size()); end
    n_cmp++; if (Busy_ob !== '0) begin n_err++; $display("FAIL reset_stays_idle: got %0h expected 0", Busy_ob); end
  endtask

  task automatic test_basic_move();
    bit ok;
    clear_dq();
    send_cmd(3, 4, 1'b1, 1'b0, 2);
    wait_done(1, 600, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_timeout: got no done expected 1"); end
    if (ok) begin
      n_cmp++; if (dq_m[0] != 3 || dq_s[0] != 0) begin n_err++; $display("FAIL basic_done: got m%0d s%0d expected m3 s0", dq_m[0], dq_s[0]); end
      n_cmp++; if (dq_b[0] != 0) begin n_err++; $display("FAIL basic_busy_drop: got %0d expected 0", dq_b[0]); end
    end
    n_cmp++; if (rise_cnt[3] - base_rise[3] != 4) begin n_err++; $display("FAIL basic_pulses: got %0d expected 4", rise_cnt[3] - base_rise[3]); end
    n_cmp++; if (bad_w[3] != base_bad[3]) begin n_err++; $display("FAIL basic_width: got %0d bad widths expected 0 (32 clk)", bad_w[3] - base_bad[3]); end
    n_cmp++; if ({pl_en_ob[3], pl_dir_ob[3], pl_clk_ob[3], Busy_ob[3]} !== 4'b1100) begin
      n_err++; $display("FAIL basic_end_state: got %b expected 1100", {pl_en_ob[3], pl_dir_ob[3], pl_clk_ob[3], Busy_ob[3]}); end
  endtask

  task automatic test_limit();
    bit ok;
    int lat;
    clear_dq();
    send_cmd(0, 100, 1'b1, 1'b0, 1);
    wait_pulses(0, 10);
    pl_sw_outa_ib[0] = 1'b1;
    lat = 0;
    while (pl_clk_ob[0] && lat < 40) begin tick(); lat++; end
    n_cmp++; if (lat > 16) begin n_err++; $display("FAIL limit_latency: got %0d clk expected <= 16", lat); end
    wait_done(1, 40, ok);
    n_cmp++; if (!ok || dq_s[0] != 1 || dq_m[0] != 0) begin n_err++; $display("FAIL limit_status: got ok%0b s%0d expected s1", ok, ok ? dq_s[0] : -1); end
    n_cmp++; if (rise_cnt[0] - base_rise[0] != 10) begin n_err++; $display("FAIL limit_pulses: got %0d expected 10", rise_cnt[0] - base_rise[0]); end
    n_cmp++; if (pl_en_ob[0] !== 1'b1) begin n_err++; $display("FAIL limit_en: got %0b expected 1", pl_en_ob[0]); end
    // Same switch, moving away from it
    clear_dq();
    send_cmd(0, 100, 1'b0, 1'b0, 1);
    wait_done(1, 3600, ok);
    n_cmp++; if (!ok || dq_s[0] != 0) begin n_err++; $display("FAIL away_status: got ok%0b s%0d expected s0", ok, ok ? dq_s[0] : -1); end
    n_cmp++; if (rise_cnt[0] - base_rise[0] != 100) begin n_err++; $display("FAIL away_pulses: got %0d expected 100", rise_cnt[0] - base_rise[0]); end
    n_cmp++; if (bad_w[0] != base_bad[0]) begin n_err++; $display("FAIL away_width: got %0d bad widths expected 0", bad_w[0] - base_bad[0]); end
    pl_sw_outa_ib[0] = 1'b0;
  endtask

  task automatic test_pfail();
    bit ok;
    clear_dq();
    send_cmd(15, 50, 1'b1, 1'b0, 1);
    wait_pulses(15, 3);
    pl_pfail_ib[15] = 1'b1;
    wait_done(1, 40, ok);
    n_cmp++; if (!ok || dq_s[0] != 2 || dq_m[0] != 15) begin n_err++; $display("FAIL pfail_status: got ok%0b s%0d expected m15 s2", ok, ok ? dq_s[0] : -1); end
    n_cmp++; if ({pl_en_ob[15], Fault_ob[15], pl_clk_ob[15], Busy_ob[15]} !== 4'b0100) begin
      n_err++; $display("FAIL pfail_state: got %b expected 0100", {pl_en_ob[15], Fault_ob[15], pl_clk_ob[15], Busy_ob[15]}); end
    pl_pfail_ib[15] = 1'b0;
    clear_dq();
    send_cmd(15, 1, 1'b1, 1'b0, 1);
    n_cmp++; if ({Fault_ob[15], pl_en_ob[15], Busy_ob[15]} !== 3'b011) begin
      n_err++; $display("FAIL pfail_clear: got %b expected 011", {Fault_ob[15], pl_en_ob[15], Busy_ob[15]}); end
    wait_done(1, 100, ok);
    n_cmp++; if (!ok || dq_s[0] != 0 || rise_cnt[15] - base_rise[15] != 1) begin
      n_err++; $display("FAIL pfail_rerun: got ok%0b pulses %0d expected 1", ok, rise_cnt[15] - base_rise[15]); end
  endtask

  task automatic test_zero_steps();
    bit ok;
    clear_dq();
    send_cmd(7, 0, 1'b1, 1'b0, 3);
    wait_done(1, 20, ok);
    n_cmp++; if (!ok || dq_m[0] != 7 || dq_s[0] != 0) begin n_err++; $display("FAIL zero_done: got ok%0b expected m7 s0", ok); end
    n_cmp++; if (rise_cnt[7] != base_rise[7]) begin n_err++; $display("FAIL zero_pulses: got %0d expected 0", rise_cnt[7] - base_rise[7]); end
  endtask

  task automatic test_back_to_back();
    bit ok, accepted;
    int viol, k, first_pulses, first_dones;
    clear_dq();
    send_cmd(7, 3, 1'b0, 1'b0, 1);
    tick();
    CmdValid_i = 1'b1; CmdMotor_ib = 4'd7; CmdSteps_ib = SW'(2); CmdDir_i = 1'b1; CmdHalfPer_ib = DW'(1);
    viol = 0; accepted = 1'b0; k = 0; first_pulses = -1; first_dones = -1;
    while (!accepted && k < 400) begin
      if (Busy_ob[7] && (CmdReady_o || pl_dir_ob[7])) viol++;
      if (!Busy_ob[7]) begin
        first_pulses = rise_cnt[7] - base_rise[7];
        first_dones  = dq_m.size();
        base_rise[7] = rise_cnt[7];
        base_bad[7]  = bad_w[7];
        @(posedge Clk_ik);
        #1;
        accepted = 1'b1;
      end else begin
        tick();
      end
      k++;
    end
    CmdValid_i = 1'b0;
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL hold_ready: got %0d busy cycles with ready/dir change expected 0", viol); end
    n_cmp++; if (!accepted || first_pulses != 3 || first_dones != 1) begin
      n_err++; $display("FAIL hold_first_job: got pulses %0d dones %0d expected 3 1", first_pulses, first_dones); end
    n_cmp++; if ({Busy_ob[7], pl_dir_ob[7]} !== 2'b11) begin n_err++; $display("FAIL hold_second_start: got %b expected 11", {Busy_ob[7], pl_dir_ob[7]}); end
    wait_done(2, 200, ok);
    n_cmp++; if (!ok || dq_s[1] != 0 || rise_cnt[7] - base_rise[7] != 2) begin
      n_err++; $display("FAIL hold_second_job: got ok%0b pulses %0d expected 2", ok, rise_cnt[7] - base_rise[7]); end
  endtask

  task automatic test_same_round();
    bit ok;
    clear_dq();
    send_cmd(1, 100, 1'b1, 1'b0, 1);
    send_cmd(2, 100, 1'b1, 1'b0, 1);
    wait_pulses(1, 1);
    tick();
    Abort_ib[1] = 1'b1; Abort_ib[2] = 1'b1;
    wait_done(2, 40, ok);
    Abort_ib = '0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL round_timeout: got %0d dones expected 2", dq_m.size()); end
    if (ok) begin
      n_cmp++; if (dq_m[0] != 1 || dq_m[1] != 2 || dq_s[0] != 3 || dq_s[1] != 3) begin
        n_err++; $display("FAIL round_order: got m%0d s%0d m%0d s%0d expected m1 s3 m2 s3", dq_m[0], dq_s[0], dq_m[1], dq_s[1]); end
      n_cmp++; if (dq_c[1] - dq_c[0] != 1) begin n_err++; $display("FAIL round_spacing: got %0d clk expected 1", dq_c[1] - dq_c[0]); end
    end
    n_cmp++; if ({pl_en_ob[2:1], pl_clk_ob[2:1]} !== 4'b1100) begin
      n_err++; $display("FAIL round_end_state: got %b expected 1100", {pl_en_ob[2:1], pl_clk_ob[2:1]}); end
  endtask

  task automatic test_release();
    bit ok;
    logic [NM-1:0] en_before, busy_now;
    clear_dq();
    send_cmd(4, 20, 1'b1, 1'b0, 1);
    repeat (3) tick();
    en_before = pl_en_ob;
    busy_now  = Busy_ob;
    n_cmp++; if (en_before[3] !== 1'b1) begin n_err++; $display("FAIL release_pre_en3: got %0b expected 1", en_before[3]); end
    Release_ib = '1;
    tick();
    Release_ib = '0;
    n_cmp++; if (pl_en_ob !== (en_before & busy_now)) begin
      n_err++; $display("FAIL release_en: got %0h expected %0h", pl_en_ob, en_before & busy_now); end
    Abort_ib = ~busy_now;
    repeat (20) tick();
    Abort_ib = '0;
    n_cmp++; if (dq_m.size() != 0 || Busy_ob[4] !== 1'b1) begin
      n_err++; $display("FAIL abort_idle: got %0d dones busy4=%0b expected 0 1", dq_m.size(), Busy_ob[4]); end
    Abort_ib[4] = 1'b1;
    wait_done(1, 40, ok);
    Abort_ib = '0;
    n_cmp++; if (!ok || dq_s[0] != 3 || pl_en_ob[4] !== 1'b1) begin
      n_err++; $display("FAIL abort_busy: got ok%0b en4=%0b expected s3 en 1", ok, pl_en_ob[4]); end
    clear_dq();
    pl_pfail_ib[4] = 1'b1;
    repeat (20) tick();
    pl_pfail_ib[4] = 1'b0;
    n_cmp++; if ({pl_en_ob[4], Fault_ob[4]} !== 2'b01 || dq_m.size() != 0) begin
      n_err++; $display("FAIL idle_pfail: got en%0b fault%0b dones %0d expected 0 1 0", pl_en_ob[4], Fault_ob[4], dq_m.size()); end
  endtask

  task automatic test_boost();
    bit ok;
    int viol, k;
    logic [NM-1:0] exp_b;
    clear_dq();
    send_cmd(6, 2, 1'b1, 1'b1, 1);
    viol = 0; k = 0;
    while (dq_m.size() < 1 && k < 200) begin
      exp_b = (BOOST_EN && Busy_ob[6]) ? NM'(1 << 6) : '0;
      if (pl_boost_ob !== exp_b) viol++;
      tick();
      k++;
    end
    ok = (dq_m.size() >= 1);
    n_cmp++; if (!ok || viol != 0) begin n_err++; $display("FAIL boost_during: got %0d wrong cycles ok%0b expected 0", viol, ok); end
    n_cmp++; if (pl_boost_ob !== '0) begin n_err++; $display("FAIL boost_after: got %0h expected 0", pl_boost_ob); end
  endtask

  task automatic test_random();
    bit ok;
    int nm, cnt, st_got, bsy;
    int mot[5], stp[5], hp[5], exp_s[5];
    bit dr[5];
    bit used[NM];
    for (int r = 0; r < 6; r++) begin
      for (int m = 0; m < NM; m++) used[m] = 1'b0;
      nm = $urandom_range(1, 5);
      tick();
      for (int i = 0; i < nm; i++) begin
        do mot[i] = $urandom_range(0, NM - 1); while (used[mot[i]]);
        used[mot[i]] = 1'b1;
        stp[i] = $urandom_range(0, 5);
        hp[i]  = $urandom_range(0, 3);
        dr[i]  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0: begin pl_pfail_ib[mot[i]] = 1'b1; exp_s[i] = 2; end
          1: begin Abort_ib[mot[i]] = 1'b1; exp_s[i] = 3; end
          2: begin if (dr[i]) pl_sw_outa_ib[mot[i]] = 1'b1; else pl_sw_outb_ib[mot[i]] = 1'b1; exp_s[i] = 1; end
          3: begin if (dr[i]) pl_sw_outb_ib[mot[i]] = 1'b1; else pl_sw_outa_ib[mot[i]] = 1'b1; exp_s[i] = 0; end
          default: exp_s[i] = 0;
        endcase
      end
      clear_dq();
      for (int i = 0; i < nm; i++) send_cmd(mot[i], stp[i], dr[i], 1'b0, hp[i]);
      wait_done(nm, 1500, ok);
      pl_pfail_ib = '0; Abort_ib = '0; pl_sw_outa_ib = '0; pl_sw_outb_ib = '0;
      n_cmp++; if (!ok || dq_m.size() != nm) begin n_err++; $display("FAIL rnd%0d_dones: got %0d expected %0d", r, dq_m.size(), nm); end
      bsy = 0;
      foreach (dq_b[j]) bsy += dq_b[j];
      n_cmp++; if (bsy != 0) begin n_err++; $display("FAIL rnd%0d_busy_at_done: got %0d expected 0", r, bsy); end
      for (int i = 0; i < nm; i++) begin
        cnt = 0; st_got = -1;
        foreach (dq_m[j]) if (dq_m[j] == mot[i]) begin cnt++; st_got = dq_s[j]; end
        n_cmp++; if (cnt != 1 || st_got != exp_s[i]) begin
          n_err++; $display("FAIL rnd%0d_m%0d_status: got n%0d s%0d expected n1 s%0d", r, mot[i], cnt, st_got, exp_s[i]); end
        n_cmp++; if (rise_cnt[mot[i]] - base_rise[mot[i]] != ((exp_s[i] == 0) ? stp[i] : 0)) begin
          n_err++; $display("FAIL rnd%0d_m%0d_pulses: got %0d expected %0d", r, mot[i], rise_cnt[mot[i]] - base_rise[mot[i]], (exp_s[i] == 0) ? stp[i] : 0); end
        n_cmp++; if (bad_w[mot[i]] != base_bad[mot[i]]) begin
          n_err++; $display("FAIL rnd%0d_m%0d_width: got %0d bad expected 0 (half %0d)", r, mot[i], bad_w[mot[i]] - base_bad[mot[i]], exp_half[mot[i]]); end
        n_cmp++; if ({pl_en_ob[mot[i]], Fault_ob[mot[i]], pl_dir_ob[mot[i]]} !== {exp_s[i] != 2, exp_s[i] == 2, dr[i]}) begin
          n_err++; $display("FAIL rnd%0d_m%0d_state: got %b expected %b", r, mot[i],
            {pl_en_ob[mot[i]], Fault_ob[mot[i]], pl_dir_ob[mot[i]]}, {exp_s[i] != 2, exp_s[i] == 2, dr[i]}); end
      end
      repeat (3) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_limit();
    test_pfail();
    test_zero_steps();
    test_back_to_back();
    test_same_round();
    test_release();
    test_boost();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
